// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (IF) and a
//   load/store requester (DM). Data requests win when both arrive together,
//   after which the two sides strictly alternate so neither starves. The
//   granted request's address/we/wdata are captured on the grant edge and held
//   for the whole access. An access that waits 16 cycles without mem_ready is
//   aborted with a done pulse, zero read data and a sticky err flag.
//
// Ports
//   clk, reset          clock, async active-high reset
//   if_req/if_addr      fetch request (held until if_done)
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_done)
//   mem_rdata/mem_ready shared memory response
//   mem_en/mem_we/mem_addr/mem_wdata  shared memory command
//   if_done/if_rdata, dm_done/dm_rdata  completion pulse + read data
//   if_stall/dm_stall   requester must hold
//   err                 sticky timeout flag
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        if_done,
    output logic        dm_done,
    output logic [63:0] if_rdata,
    output logic [63:0] dm_rdata,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_wait_cnt;
    logic        r_err;
    logic        r_mem_we;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    logic w_serve, w_timeout, w_fin, w_grant_if, w_grant_dm;

    assign w_serve   = (r_state != IDLE);
    // 16th consecutive cycle without mem_ready: give up on this access
    assign w_timeout = w_serve && !mem_ready && (r_wait_cnt == 4'hF);
    assign w_fin     = w_serve && (mem_ready || w_timeout);

    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req)      w_grant_dm = 1'b1;
                else if (if_req) w_grant_if = 1'b1;
            end
            // the side just served is consumed; only the other side may follow
            SERVE_DM: if (w_fin) begin
                if (if_req) w_grant_if = 1'b1;
                else        w_next     = IDLE;
            end
            SERVE_IF: if (w_fin) begin
                if (dm_req) w_grant_dm = 1'b1;
                else        w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_grant_dm) w_next = SERVE_DM;
        if (w_grant_if) w_next = SERVE_IF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 4'd0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_grant_dm) begin
                r_mem_addr  <= dm_addr;
                r_mem_we    <= dm_we;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_if) begin
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= 64'd0;
            end
            if (w_grant_dm || w_grant_if)  r_wait_cnt <= 4'd0;
            else if (w_serve && !mem_ready) r_wait_cnt <= r_wait_cnt + 4'd1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign mem_en    = w_serve;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

    assign if_done  = (r_state == SERVE_IF) && w_fin;
    assign dm_done  = (r_state == SERVE_DM) && w_fin;
    // a timeout completes with mem_ready low, so its read data is zero here too
    assign if_rdata = ((r_state == SERVE_IF) && mem_ready) ? mem_rdata : 64'd0;
    assign dm_rdata = ((r_state == SERVE_DM) && mem_ready && !r_mem_we) ? mem_rdata : 64'd0;
    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model (who owns
// the port, how long it has waited, what was captured at grant) is checked
// against the DUT every falling edge, plus hand-computed literal checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [63:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        mem_en, mem_we, if_done, dm_done, if_stall, dm_stall, err;
    logic [63:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .if_done(if_done), .dm_done(dm_done), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = fetch, 2 = data
    int          m_owner = 0;
    int          m_waited = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = 0; m_waited = 0; m_err = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        end else begin
            int  want;
            bit  finished;
            want = -1;
            finished = (m_owner != 0) && (mem_ready || m_waited == 15);
            if (m_owner != 0 && !mem_ready && m_waited == 15) m_err = 1;
            if (m_owner != 0 && !finished) m_waited++;
            if (m_owner == 0)       want = dm_req ? 2 : (if_req ? 1 : 0);
            else if (finished)      want = (m_owner == 2) ? (if_req ? 1 : 0) : (dm_req ? 2 : 0);
            if (want == 2) begin
                m_owner = 2; m_waited = 0; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            end else if (want == 1) begin
                m_owner = 1; m_waited = 0; m_addr = if_addr; m_we = 0; m_wdata = '0;
            end else if (want == 0) begin
                m_owner = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit fin, e_ifd, e_dmd;
        fin   = (m_owner != 0) && (mem_ready || m_waited == 15);
        e_ifd = (m_owner == 1) && fin;
        e_dmd = (m_owner == 2) && fin;
        chk("mem_en",    mem_en,    64'(m_owner != 0));
        chk("mem_we",    mem_we,    64'(m_we));
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_done",   if_done,   64'(e_ifd));
        chk("dm_done",   dm_done,   64'(e_dmd));
        chk("if_rdata",  if_rdata,  (m_owner == 1 && mem_ready) ? mem_rdata : 64'd0);
        chk("dm_rdata",  dm_rdata,  (m_owner == 2 && mem_ready && !m_we) ? mem_rdata : 64'd0);
        chk("if_stall",  if_stall,  64'(if_req && !e_ifd));
        chk("dm_stall",  dm_stall,  64'(dm_req && !e_dmd));
        chk("err",       err,       64'(m_err));
    end

    // waits (bounded) for a done pulse; n = number of falling edges seen, 0 on expiry
    task automatic wait_done(input bit dm, input int maxc, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (dm ? dm_done : if_done) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("wait_bound", 64'd0, 64'd1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [11:0] seq;
        int cnt;

        #1 reset = 1'b1;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_addr",   mem_addr, 0);
        chk("rst_err",    err, 0);
        step(); step();
        reset = 1'b0;

        // single fetch, ready on 2nd serve cycle
        if_req = 1; if_addr = 64'h40; mem_ready = 0;
        step();                               // serve cycle 1
        chk("s1_addr", mem_addr, 64'h40);
        chk("s1_en",   mem_en, 1);
        step();                               // serve cycle 2
        mem_ready = 1; mem_rdata = 64'h00A00093;
        @(negedge clk);
        chk("s1_done",  if_done, 1);
        chk("s1_rdata", if_rdata, 64'h00A00093);
        chk("s1_we",    mem_we, 0);
        step();
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        chk("s1_stall", if_stall, 0);
        chk("s1_idle",  mem_en, 0);

        // simultaneous: DM store first, then IF with no gap
        step();
        if_req = 1; if_addr = 64'h200; dm_req = 1; dm_we = 1;
        dm_addr = 64'h100; dm_wdata = 64'h5; mem_ready = 1; mem_rdata = 64'h77;
        step();
        @(negedge clk);
        chk("s2_we",     mem_we, 1);
        chk("s2_addr",   mem_addr, 64'h100);
        chk("s2_wdata",  mem_wdata, 64'h5);
        chk("s2_dmdone", dm_done, 1);
        chk("s2_ifstl",  if_stall, 1);
        chk("s2_dmrd",   dm_rdata, 0);
        step();
        dm_req = 0;
        @(negedge clk);
        chk("s2_ifen",   mem_en, 1);
        chk("s2_ifaddr", mem_addr, 64'h200);
        chk("s2_ifdone", if_done, 1);
        step();
        if_req = 0;
        step();

        // alternation with both requests held
        if_req = 1; if_addr = 64'h340; dm_req = 1; dm_we = 0; dm_addr = 64'h300;
        seq = '0; cnt = 0;
        for (int c = 0; c < 20 && cnt < 6; c++) begin
            @(negedge clk);
            if (dm_done)      begin seq = {seq[9:0], 2'b10}; cnt++; end
            else if (if_done) begin seq = {seq[9:0], 2'b01}; cnt++; end
        end
        chk("s3_count", 64'(cnt), 6);
        chk("s3_order", 64'(seq), 64'(12'b10_01_10_01_10_01));
        step();
        if_req = 0; dm_req = 0;
        step(); step();

        // timeout on a DM load
        mem_ready = 0; mem_rdata = 64'hDEAD_BEEF; dm_req = 1; dm_we = 0; dm_addr = 64'h500;
        wait_done(1, 40, n);
        chk("s4_cycles", 64'(n), 17);
        chk("s4_rdata",  dm_rdata, 0);
        chk("s4_addr",   mem_addr, 64'h500);
        step();
        dm_req = 0; if_req = 1; if_addr = 64'h600; mem_ready = 1; mem_rdata = 64'h1234;
        @(negedge clk);
        chk("s4_err", err, 1);
        wait_done(0, 10, n);
        chk("s4_ifcyc",  64'(n), 1);
        chk("s4_ifdata", if_rdata, 64'h1234);
        chk("s4_err2",   err, 1);
        step();
        if_req = 0;
        step();

        // reset in the 3rd serve cycle of a fetch
        mem_ready = 0; if_req = 1; if_addr = 64'h40;
        step(); step();
        @(posedge clk); #2;
        reset = 1; dm_req = 1; dm_we = 1; dm_addr = 64'h700; dm_wdata = 64'h77;
        #1;
        chk("s5_en",   mem_en, 0);
        chk("s5_done", if_done, 0);
        chk("s5_err",  err, 0);
        chk("s5_addr", mem_addr, 0);
        chk("s5_we",   mem_we, 0);
        step();
        reset = 0; mem_ready = 1;
        wait_done(1, 5, n);
        chk("s5_dmcyc",  64'(n), 2);
        chk("s5_dmaddr", mem_addr, 64'h700);
        chk("s5_dmwe",   mem_we, 1);
        step();
        dm_req = 0;
        wait_done(0, 5, n);
        chk("s5_ifcyc", 64'(n), 1);
        step();
        if_req = 0; mem_ready = 0;
        step();

        // request inputs change mid-access
        if_req = 1; if_addr = 64'h40;
        step();
        if_addr = 64'h80; dm_addr = 64'h999; dm_we = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s6_hold", mem_addr, 64'h40);
            chk("s6_wait", if_done, 0);
            step();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("s6_done", if_done, 1);
        chk("s6_addr", mem_addr, 64'h40);
        step();
        if_req = 0; mem_ready = 0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
